// File: rtl/axi4_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite slave port among NUM_MASTERS masters.
// One transaction (write or read) is in flight at a time; all other masters are held off.
module axi4_lite_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_MASTERS-1:0]                      m_axi_awvalid,
  output logic [NUM_MASTERS-1:0]                      m_axi_awready,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]      m_axi_awaddr,
  input  logic [NUM_MASTERS-1:0]                      m_axi_wvalid,
  output logic [NUM_MASTERS-1:0]                      m_axi_wready,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      m_axi_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]    m_axi_wstrb,
  output logic [NUM_MASTERS-1:0]                      m_axi_bvalid,
  input  logic [NUM_MASTERS-1:0]                      m_axi_bready,
  output logic [NUM_MASTERS-1:0]                      m_axi_bresp,
  input  logic [NUM_MASTERS-1:0]                      m_axi_arvalid,
  output logic [NUM_MASTERS-1:0]                      m_axi_arready,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [NUM_MASTERS-1:0]                      m_axi_rvalid,
  input  logic [NUM_MASTERS-1:0]                      m_axi_rready,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      m_axi_rdata,
  output logic [NUM_MASTERS-1:0]                      m_axi_rresp,
  output logic                                        s_axi_awvalid,
  input  logic                                        s_axi_awready,
  output logic [ADDR_WIDTH-1:0]                       s_axi_awaddr,
  output logic                                        s_axi_wvalid,
  input  logic                                        s_axi_wready,
  output logic [DATA_WIDTH-1:0]                       s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                     s_axi_wstrb,
  input  logic                                        s_axi_bvalid,
  output logic                                        s_axi_bready,
  input  logic                                        s_axi_bresp,
  output logic                                        s_axi_arvalid,
  input  logic                                        s_axi_arready,
  output logic [ADDR_WIDTH-1:0]                       s_axi_araddr,
  input  logic                                        s_axi_rvalid,
  output logic                                        s_axi_rready,
  input  logic [DATA_WIDTH-1:0]                       s_axi_rdata,
  input  logic                                        s_axi_rresp,
  output logic [NUM_MASTERS-1:0]                      grant,
  output logic                                        busy
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr, gidx, sel_idx;
  logic                   sel_found;
  logic [31:0]            cand;
  logic                   aw_done, w_done;
  logic [NUM_MASTERS-1:0] req;
  logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req   = m_axi_awvalid | m_axi_wvalid | m_axi_arvalid;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;
  assign busy  = reset && (state != IDLE);

  // First requester at or after rr_ptr, wrapping; both operands < NUM_MASTERS so one subtract suffices.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!sel_found && req[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found)
                 state_nxt = (m_axi_awvalid[sel_idx] | m_axi_wvalid[sel_idx]) ? WRITE : READ;
      WRITE:   if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WRESP;
      WRESP:   if (b_hs) state_nxt = IDLE;
      READ:    if (ar_hs) state_nxt = RRESP;
      RRESP:   if (r_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Forwarding is gated by reset so nothing leaks out while reset is held.
  always_comb begin
    m_axi_awready = '0;
    m_axi_wready  = '0;
    m_axi_bvalid  = '0;
    m_axi_bresp   = '0;
    m_axi_arready = '0;
    m_axi_rvalid  = '0;
    m_axi_rdata   = '0;
    m_axi_rresp   = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    s_axi_awaddr  = m_axi_awaddr[gidx];
    s_axi_wdata   = m_axi_wdata[gidx];
    s_axi_wstrb   = m_axi_wstrb[gidx];
    s_axi_araddr  = m_axi_araddr[gidx];
    if (reset) begin
      case (state)
        WRITE: begin
          s_axi_awvalid       = m_axi_awvalid[gidx] & ~aw_done;
          m_axi_awready[gidx] = s_axi_awready & ~aw_done;
          s_axi_wvalid        = m_axi_wvalid[gidx] & ~w_done;
          m_axi_wready[gidx]  = s_axi_wready & ~w_done;
        end
        WRESP: begin
          s_axi_bready       = m_axi_bready[gidx];
          m_axi_bvalid[gidx] = s_axi_bvalid;
          m_axi_bresp[gidx]  = s_axi_bresp;
        end
        READ: begin
          s_axi_arvalid       = m_axi_arvalid[gidx];
          m_axi_arready[gidx] = s_axi_arready;
        end
        RRESP: begin
          s_axi_rready       = m_axi_rready[gidx];
          m_axi_rvalid[gidx] = s_axi_rvalid;
          m_axi_rdata[gidx]  = s_axi_rdata;
          m_axi_rresp[gidx]  = s_axi_rresp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gidx    <= '0;
      grant   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_found) begin
        gidx  <= sel_idx;
        grant <= NUM_MASTERS'(1) << sel_idx;
      end
      if (state == WRITE) begin
        if (state_nxt == WRESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
        end
      end
      if ((state == WRESP || state == RRESP) && state_nxt == IDLE) begin
        grant  <= '0;
        rr_ptr <= (32'(gidx) == NUM_MASTERS - 1) ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// Bench for axi4_lite_rr_arbiter with three masters: directed scenarios plus random
// transactions, checked against a transaction-level round-robin model.
module tb_axi4_lite_rr_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, m_bresp;
  logic [2:0]       m_arvalid, m_arready, m_rvalid, m_rready, m_rresp;
  logic [2:0][15:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0][1:0]  m_wstrb;
  logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, s_bresp;
  logic             s_arvalid, s_arready, s_rvalid, s_rready, s_rresp;
  logic [15:0]      s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [1:0]       s_wstrb;
  logic [2:0]       grant;
  logic             busy;

  axi4_lite_rr_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready), .m_axi_awaddr(m_awaddr),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_bresp(m_bresp),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_araddr(m_araddr),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
    .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready), .s_axi_awaddr(s_awaddr),
    .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready), .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb),
    .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready), .s_axi_bresp(s_bresp),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready), .s_axi_araddr(s_araddr),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
    .grant(grant), .busy(busy)
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned rr_model = 0;
  int unsigned wbeats = 0;
  bit          use_fixed = 1'b0;

  always @(posedge clk) if (s_wvalid && s_wready) wbeats <= wbeats + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int unsigned g);
    oh = 3'b001 << g;
  endfunction

  // One arbitration plus complete transaction, starting and ending on a negedge with the DUT idle.
  task automatic do_txn(input logic [2:0] wr, input logic [2:0] rd, input int unsigned daw,
                        input int unsigned dw, input int unsigned dr);
    int unsigned g, c, last, base;
    bit          found, is_wr;
    logic [2:0]  gv;
    logic [2:0][15:0] erd;
    for (int i = 0; i < 3; i++) begin
      m_awaddr[i] = 16'($urandom);
      m_araddr[i] = 16'($urandom);
      m_wdata[i]  = 16'($urandom);
      m_wstrb[i]  = 2'($urandom);
    end
    if (use_fixed) begin
      m_awaddr[0] = 16'h0010;
      m_wdata[0]  = 16'hBEEF;
    end
    m_awvalid = wr; m_wvalid = wr; m_arvalid = rd; m_bready = '1; m_rready = '1;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_bvalid = 1'($urandom); s_rvalid = 1'($urandom);
    g = 0; found = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      c = (rr_model + i) % 3;
      if (!found && (wr[c] | rd[c])) begin found = 1'b1; g = c; end
    end
    is_wr = wr[g];
    gv = oh(g);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    chk("idle_s_awvalid", s_awvalid, 0);
    chk("idle_s_arvalid", s_arvalid, 0);
    chk("idle_m_bvalid", m_bvalid, 0);
    chk("idle_m_rvalid", m_rvalid, 0);
    chk("idle_s_bready", s_bready, 0);
    chk("idle_s_rready", s_rready, 0);
    @(negedge clk);
    chk("grant", grant, gv);
    chk("busy_granted", busy, 1);
    if (is_wr) begin
      base = wbeats;
      last = (daw > dw) ? daw : dw;
      for (int unsigned k = 0; k <= last; k++) begin
        s_awready = (k >= daw); s_wready = (k >= dw);
        s_bvalid = 1'($urandom); s_rvalid = 1'($urandom);
        #1;
        chk("s_awvalid", s_awvalid, k <= daw);
        chk("s_wvalid", s_wvalid, k <= dw);
        if (k <= daw) chk("s_awaddr", s_awaddr, m_awaddr[g]);
        if (k <= dw) chk("s_wdata", {s_wstrb, s_wdata}, {m_wstrb[g], m_wdata[g]});
        chk("m_awready", m_awready, (k == daw) ? gv : 3'b0);
        chk("m_wready", m_wready, (k == dw) ? gv : 3'b0);
        chk("wr_m_bvalid", m_bvalid, 0);
        chk("wr_s_bready", s_bready, 0);
        chk("wr_m_arready", m_arready, 0);
        chk("wr_busy", busy, 1);
        @(negedge clk);
      end
      s_awready = 1'b0; s_wready = 1'b0;
      chk("w_beats", wbeats - base, 1);
      for (int unsigned k = 0; k <= dr; k++) begin
        s_bvalid = (k == dr); s_bresp = use_fixed ? 1'b0 : 1'($urandom); s_rvalid = 1'($urandom);
        #1;
        chk("m_bvalid", m_bvalid, (k == dr) ? gv : 3'b0);
        chk("m_bresp", m_bresp, s_bresp ? gv : 3'b0);
        chk("s_bready", s_bready, 1);
        chk("wresp_m_awready", m_awready, 0);
        chk("wresp_m_wready", m_wready, 0);
        chk("wresp_m_arready", m_arready, 0);
        chk("wresp_m_rvalid", m_rvalid, 0);
        chk("wresp_s_awvalid", s_awvalid, 0);
        chk("wresp_busy", busy, 1);
        @(negedge clk);
      end
    end else begin
      for (int unsigned k = 0; k <= daw; k++) begin
        s_arready = (k == daw); s_bvalid = 1'($urandom); s_rvalid = 1'($urandom);
        #1;
        chk("s_arvalid", s_arvalid, 1);
        chk("s_araddr", s_araddr, m_araddr[g]);
        chk("m_arready", m_arready, (k == daw) ? gv : 3'b0);
        chk("rd_s_rready", s_rready, 0);
        chk("rd_m_rvalid", m_rvalid, 0);
        chk("rd_m_bvalid", m_bvalid, 0);
        chk("rd_s_awvalid", s_awvalid, 0);
        @(negedge clk);
      end
      s_arready = 1'b0;
      for (int unsigned k = 0; k <= dr; k++) begin
        s_rvalid = (k == dr); s_rdata = 16'($urandom); s_rresp = 1'($urandom); s_bvalid = 1'($urandom);
        #1;
        erd = '0;
        erd[g] = s_rdata;
        chk("m_rvalid", m_rvalid, (k == dr) ? gv : 3'b0);
        chk("m_rdata", m_rdata, erd);
        chk("m_rresp", m_rresp, s_rresp ? gv : 3'b0);
        chk("s_rready", s_rready, 1);
        chk("rresp_m_arready", m_arready, 0);
        chk("rresp_m_bvalid", m_bvalid, 0);
        chk("rresp_busy", busy, 1);
        @(negedge clk);
      end
    end
    s_bvalid = 1'b0; s_rvalid = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_grant", grant, 0);
    rr_model = (g + 1) % 3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] wr, rd;
    reset = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '1; m_rready = '1;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_bvalid = 1'b1; s_rvalid = 1'b1; s_bresp = 1'b0; s_rresp = 1'b0; s_rdata = '0;
    @(negedge clk);
    #1;
    chk("rst_during_s_rready", s_rready, 0);
    chk("rst_during_m_bvalid", m_bvalid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_valids", {s_awvalid, s_wvalid, s_arvalid, s_bready}, 0);
    reset = 1'b1;
    #1;
    chk("rst_after_m_readies", {m_awready, m_wready, m_arready, m_rvalid}, 0);
    chk("rst_after_s_valids", {s_awvalid, s_wvalid, s_arvalid, s_rready}, 0);

    // Single M0 write at 0x0010, slave ready immediately
    use_fixed = 1'b1;
    do_txn(3'b001, 3'b000, 0, 0, 0);
    use_fixed = 1'b0;
    // M0 and M1 reading back to back
    for (int i = 0; i < 4; i++) do_txn(3'b000, 3'b011, $urandom_range(0, 2), 0, $urandom_range(0, 2));
    // W accepted three cycles before AW
    do_txn(3'b100, 3'b000, 3, 0, 1);
    // M1 with AW and AR together: write first, read afterwards
    do_txn(3'b010, 3'b010, 0, 1, 0);
    do_txn(3'b000, 3'b010, 1, 0, 0);
    // Slow B with every master requesting
    do_txn(3'b111, 3'b111, 0, 0, 20);

    // Abort in RRESP: leave rr_ptr at 2, then regrant must scan from 0
    do_txn(3'b000, 3'b010, 0, 0, 0);
    m_arvalid = 3'b010; m_rready = '0; #1;
    @(negedge clk);
    chk("abort_grant", grant, 3'b010);
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; #1;
    chk("abort_pre_m_rvalid", m_rvalid, 3'b010);
    reset = 1'b0; #1;
    chk("abort_during_m_rvalid", m_rvalid, 0);
    chk("abort_during_s_rready", s_rready, 0);
    @(negedge clk);
    chk("abort_grant_cleared", grant, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valids", {m_rvalid, m_arready, s_arvalid, s_rready, s_awvalid}, 0);
    s_rvalid = 1'b0; m_rready = '1; m_arvalid = 3'b110; reset = 1'b1; rr_model = 0; #1;
    chk("abort_release_busy", busy, 0);
    @(negedge clk);
    chk("abort_regrant", grant, 3'b010);
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; m_arvalid = '0; s_rvalid = 1'b1;
    @(negedge clk);
    s_rvalid = 1'b0; #1;
    chk("abort_finish_busy", busy, 0);
    rr_model = 2;

    for (int t = 0; t < 30; t++) begin
      do begin
        wr = 3'($urandom); rd = 3'($urandom);
      end while ((wr | rd) == 3'b000);
      do_txn(wr, rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_rr_arbiter.md
AXI4_LITE_RR_ARBITER -- requirements
Module: axi4_lite_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of AXI4-lite master ports sharing one slave port; legal range 2..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: data width, a multiple of 8.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low; reset==0 at a rising clk edge resets the block.
REQ-006 SHALL have master-side ports m_axi_{awvalid,wvalid,bready,arvalid,rready}, input, [NUM_MASTERS]: per-master handshake inputs.
REQ-007 SHALL have ports m_axi_awaddr/m_axi_araddr, input, [NUM_MASTERS][ADDR_WIDTH]; m_axi_wdata, input, [NUM_MASTERS][DATA_WIDTH]; m_axi_wstrb, input, [NUM_MASTERS][DATA_WIDTH/8].
REQ-008 SHALL have ports m_axi_{awready,wready,bvalid,bresp,arready,rvalid,rresp}, output, [NUM_MASTERS]; m_axi_rdata, output, [NUM_MASTERS][DATA_WIDTH].
REQ-009 SHALL have slave-side ports s_axi_* with the same names and single-port widths, directions mirrored; bresp/rresp are 1 bit.
REQ-010 SHALL have port grant, output, [NUM_MASTERS]: one-hot registered grant, all-zero when idle.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, WRESP, READ, RRESP.
REQ-013 A master requests when awvalid|wvalid|arvalid is high.
REQ-014 In IDLE, SHALL pick the first requesting master scanning upward from rr_ptr with wrap-around modulo NUM_MASTERS; grant and state register on that edge; no slave valid is driven in the IDLE cycle.
REQ-015 If the selected master has awvalid|wvalid, the next state SHALL be WRITE; otherwise READ. Write wins when both are pending.
REQ-016 Only the granted master's signals SHALL be forwarded; all other masters' ready/valid/resp/rdata outputs SHALL be 0.
REQ-017 In WRITE, SHALL forward AW and W independently to the slave (combinational, zero added latency); it SHALL track aw_done and w_done flags, and once a channel has handshaken, its valid to the slave and ready to the master SHALL be 0.
REQ-018 SHALL leave WRITE for WRESP on the edge where both channels are done, including when AW and W handshake in the same cycle.
REQ-019 In WRESP, SHALL forward s_axi_bvalid/bresp to the granted master and m_axi_bready to the slave; on the B handshake it SHALL go to IDLE.
REQ-020 In READ, SHALL forward AR; on the AR handshake it SHALL go to RRESP.
REQ-021 In RRESP, SHALL forward R; on the R handshake it SHALL go to IDLE.
REQ-022 On each return to IDLE, rr_ptr SHALL be set to (granted index + 1) mod NUM_MASTERS and grant SHALL clear; the minimum idle gap between grants is one cycle.
REQ-023 No channel of a non-granted master SHALL be accepted while busy, whatever its valid state.
REQ-024 A B or R arriving at the slave port outside WRESP/RRESP SHALL NOT be forwarded; s_axi_bready and s_axi_rready SHALL be 0 outside those states.
REQ-025 The block SHALL NOT time out; it holds its state until the slave completes.

Reset
REQ-026 While reset==0, the block SHALL set state=IDLE, rr_ptr=0, grant=0, busy=0, and aw_done=w_done=0.
REQ-027 During and immediately after reset, all m_axi_* ready/valid outputs and s_axi_* valid/ready outputs SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abort it; the next request after release SHALL be arbitrated from rr_ptr=0.

Verification
REQ-029 NUM_MASTERS=2, M0 write 0x0010 data 0xBEEF, slave ready at once, bresp=0:
- grant=01 one cycle after awvalid;
- AW and W complete the same cycle;
- M0 sees bvalid with bresp=0;
- rr_ptr=1 afterward.
REQ-030 M0 and M1 both issue reads continuously:
- grants alternate 01,10,01,10;
- each grant returns rdata supplied by the slave;
- an idle cycle follows each R handshake.
REQ-031 W handshakes 3 cycles before AW:
- wready to the master deasserts after the W handshake;
- state stays WRITE until the AW handshake;
- the slave sees exactly one W beat.
REQ-032 M1 asserts awvalid and arvalid together:
- the write is served first (WRITE, then WRESP);
- the read is granted in a later arbitration.
REQ-033 Reset=0 driven in RRESP with s_axi_rvalid high:
- next cycle grant=0, busy=0, all readies and valids 0;
- after release, a pending M1 request is granted (scan from 0 finds M1 if M0 is idle).
REQ-034 The slave holds bvalid=0 for 20 cycles:
- the block stays in WRESP with busy=1;
- requests from other masters get no ready.
